// File: rtl/axi_burst_ram_pkg.sv
// Shared burst/response encodings and FSM state type for the AXI4 burst RAM slave.
package axi_burst_ram_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   typedef enum logic [1:0] {StIdle, StWdata, StWresp, StRdata} state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED / INCR / WRAP bursts; shared by the write and read paths.
module axi_burst_addr_gen
   import axi_burst_ram_pkg::*;
(
   input  logic [31:0] addr_i,
   input  logic [7:0]  len_i,
   input  logic [2:0]  size_i,
   input  logic [1:0]  burst_i,
   output logic [31:0] next_addr_o
);

   logic [31:0] step;
   logic [31:0] incr;
   logic [31:0] mask;
   logic        wrap_ok;

   always_comb begin
      step    = 32'd1 << size_i;
      incr    = addr_i + step;
      mask    = (({24'd0, len_i} + 32'd1) << size_i) - 32'd1;
      // Only power-of-two beat counts form a legal wrap window; others fall back to INCR.
      wrap_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
      case (burst_i)
         BURST_FIXED: next_addr_o = addr_i;
         BURST_INCR:  next_addr_o = incr;
         BURST_WRAP:  next_addr_o = wrap_ok ? ((addr_i & ~mask) | (incr & mask)) : incr;
         default:     next_addr_o = incr;
      endcase
   end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave RAM: one transaction at a time (AW+W+B or AR+R), 64-bit data, DECERR past MEM_SIZE.
module axi_burst_ram
   import axi_burst_ram_pkg::*;
#(
   parameter int unsigned ID_WIDTH  = 8,
   parameter int unsigned MEM_SIZE  = 32'h10000,
   parameter string       INIT_FILE = ""
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ID_WIDTH-1:0] i_awid,
   input  logic [31:0]         i_awaddr,
   input  logic [7:0]          i_awlen,
   input  logic [2:0]          i_awsize,
   input  logic [1:0]          i_awburst,
   input  logic                i_awvalid,
   output logic                o_awready,
   input  logic [ID_WIDTH-1:0] i_arid,
   input  logic [31:0]         i_araddr,
   input  logic [7:0]          i_arlen,
   input  logic [2:0]          i_arsize,
   input  logic [1:0]          i_arburst,
   input  logic                i_arvalid,
   output logic                o_arready,
   input  logic [63:0]         i_wdata,
   input  logic [7:0]          i_wstrb,
   input  logic                i_wlast,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic [ID_WIDTH-1:0] o_bid,
   output logic [1:0]          o_bresp,
   output logic                o_bvalid,
   input  logic                i_bready,
   output logic [ID_WIDTH-1:0] o_rid,
   output logic [63:0]         o_rdata,
   output logic [1:0]          o_rresp,
   output logic                o_rlast,
   output logic                o_rvalid,
   input  logic                i_rready
);

   localparam int unsigned Words = MEM_SIZE / 8;
   localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;

   state_e              state_q;
   logic                last_was_write_q;
   logic [ID_WIDTH-1:0] id_q;
   logic [31:0]         addr_q;
   logic [7:0]          len_q;
   logic [7:0]          beat_q;
   logic [2:0]          size_q;
   logic [1:0]          burst_q;
   logic                werr_dec_q;
   logic                werr_slv_q;
   logic                bvalid_q;
   logic [1:0]          bresp_q;
   logic                rvalid_q;
   logic                rlast_q;
   logic [1:0]          rresp_q;
   logic [63:0]         rdata_q;
   logic                rd_done_q;

   logic [31:0]     addr_next;
   logic [IdxW-1:0] widx;
   logic            grant_w;
   logic            aw_hs;
   logic            ar_hs;
   logic            w_hs;
   logic            r_hs;
   logic            ren;
   logic            in_range;
   logic            last_beat;
   logic            wr_dec;
   logic            wr_slv;

   axi_burst_addr_gen u_addr_gen (
      .addr_i      (addr_q),
      .len_i       (len_q),
      .size_i      (size_q),
      .burst_i     (burst_q),
      .next_addr_o (addr_next)
   );

   assign in_range  = addr_q < MEM_SIZE;
   assign widx      = addr_q[IdxW+2:3];
   assign last_beat = beat_q == len_q;

   // Write wins when both are pending unless the previous grant went to a write.
   assign grant_w   = i_awvalid && (!i_arvalid || !last_was_write_q);
   assign o_awready = (state_q == StIdle) && grant_w;
   assign o_arready = (state_q == StIdle) && i_arvalid && !grant_w;
   assign o_wready  = (state_q == StWdata);

   assign aw_hs  = i_awvalid && o_awready;
   assign ar_hs  = i_arvalid && o_arready;
   assign w_hs   = i_wvalid && o_wready;
   assign r_hs   = rvalid_q && i_rready;
   assign ren    = (state_q == StRdata) && !rd_done_q && (!rvalid_q || i_rready);
   assign wr_dec = werr_dec_q || !in_range;
   assign wr_slv = werr_slv_q || (i_wlast != last_beat);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= StIdle;
         last_was_write_q <= 1'b0;
         id_q             <= '0;
         addr_q           <= '0;
         len_q            <= '0;
         beat_q           <= '0;
         size_q           <= '0;
         burst_q          <= '0;
         werr_dec_q       <= 1'b0;
         werr_slv_q       <= 1'b0;
         bvalid_q         <= 1'b0;
         bresp_q          <= RESP_OKAY;
         rvalid_q         <= 1'b0;
         rlast_q          <= 1'b0;
         rresp_q          <= RESP_OKAY;
         rd_done_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (aw_hs) begin
                  id_q             <= i_awid;
                  addr_q           <= i_awaddr;
                  len_q            <= i_awlen;
                  size_q           <= i_awsize;
                  burst_q          <= i_awburst;
                  beat_q           <= '0;
                  werr_dec_q       <= 1'b0;
                  werr_slv_q       <= 1'b0;
                  last_was_write_q <= 1'b1;
                  state_q          <= StWdata;
               end else if (ar_hs) begin
                  id_q             <= i_arid;
                  addr_q           <= i_araddr;
                  len_q            <= i_arlen;
                  size_q           <= i_arsize;
                  burst_q          <= i_arburst;
                  beat_q           <= '0;
                  rd_done_q        <= 1'b0;
                  last_was_write_q <= 1'b0;
                  state_q          <= StRdata;
               end
            end
            StWdata: begin
               if (w_hs) begin
                  addr_q     <= addr_next;
                  beat_q     <= beat_q + 8'd1;
                  werr_dec_q <= wr_dec;
                  werr_slv_q <= wr_slv;
                  if (last_beat) begin
                     bvalid_q <= 1'b1;
                     bresp_q  <= wr_dec ? RESP_DECERR : (wr_slv ? RESP_SLVERR : RESP_OKAY);
                     state_q  <= StWresp;
                  end
               end
            end
            StWresp: begin
               if (i_bready) begin
                  bvalid_q <= 1'b0;
                  bresp_q  <= RESP_OKAY;
                  state_q  <= StIdle;
               end
            end
            StRdata: begin
               if (ren) begin
                  rvalid_q  <= 1'b1;
                  rlast_q   <= last_beat;
                  rresp_q   <= in_range ? RESP_OKAY : RESP_DECERR;
                  addr_q    <= addr_next;
                  beat_q    <= beat_q + 8'd1;
                  rd_done_q <= last_beat;
               end else if (r_hs) begin
                  rvalid_q <= 1'b0;
                  if (rlast_q) begin
                     rlast_q <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   if (1) begin : ram
      logic [63:0] mem [Words];

      always_ff @(posedge clk) begin
         if (w_hs && in_range) begin
            for (int b = 0; b < 8; b++) begin
               if (i_wstrb[b]) mem[widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end

      // Read register only loads on ren, so the R payload holds while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q <= '0;
         end else if (ren) begin
            rdata_q <= in_range ? mem[widx] : 64'd0;
         end
      end
   end

   assign o_bid    = id_q;
   assign o_bresp  = bresp_q;
   assign o_bvalid = bvalid_q;
   assign o_rid    = id_q;
   assign o_rdata  = rdata_q;
   assign o_rresp  = rresp_q;
   assign o_rlast  = rlast_q;
   assign o_rvalid = rvalid_q;

endmodule

// File: tb/tb_axi_burst_ram.sv
// Directed bench for axi_burst_ram: vector table of write/read bursts plus arbitration,
// back-pressure and mid-burst reset sequences.
module tb_axi_burst_ram;
   import axi_burst_ram_pkg::*;

   typedef struct packed {
      bit              wr;
      logic [31:0]     addr;
      logic [7:0]      len;
      logic [2:0]      size;
      logic [1:0]      burst;
      int              wlast_at;
      logic [3:0][7:0] strb;
      logic [3:0][63:0] data;
      logic [3:0][1:0] resp;
   } vec_t;

   localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] D2 = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] D3 = 64'h5A5A_A5A5_0F0F_F0F0;
   localparam logic [63:0] Z  = 64'd0;
   localparam int          NumVec = 19;

   logic clk = 1'b0;
   logic rst_n;
   logic [7:0]  i_awid, i_arid, o_bid, o_rid;
   logic [31:0] i_awaddr, i_araddr;
   logic [7:0]  i_awlen, i_arlen;
   logic [2:0]  i_awsize, i_arsize;
   logic [1:0]  i_awburst, i_arburst, o_bresp, o_rresp;
   logic        i_awvalid, o_awready, i_arvalid, o_arready;
   logic [63:0] i_wdata, o_rdata;
   logic [7:0]  i_wstrb;
   logic        i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
   logic        o_rlast, o_rvalid, i_rready;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   axi_burst_ram #(
      .ID_WIDTH  (8),
      .MEM_SIZE  (32'h10000),
      .INIT_FILE ("")
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_awid    (i_awid),
      .i_awaddr  (i_awaddr),
      .i_awlen   (i_awlen),
      .i_awsize  (i_awsize),
      .i_awburst (i_awburst),
      .i_awvalid (i_awvalid),
      .o_awready (o_awready),
      .i_arid    (i_arid),
      .i_araddr  (i_araddr),
      .i_arlen   (i_arlen),
      .i_arsize  (i_arsize),
      .i_arburst (i_arburst),
      .i_arvalid (i_arvalid),
      .o_arready (o_arready),
      .i_wdata   (i_wdata),
      .i_wstrb   (i_wstrb),
      .i_wlast   (i_wlast),
      .i_wvalid  (i_wvalid),
      .o_wready  (o_wready),
      .o_bid     (o_bid),
      .o_bresp   (o_bresp),
      .o_bvalid  (o_bvalid),
      .i_bready  (i_bready),
      .o_rid     (o_rid),
      .o_rdata   (o_rdata),
      .o_rresp   (o_rresp),
      .o_rlast   (o_rlast),
      .o_rvalid  (o_rvalid),
      .i_rready  (i_rready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit wr, logic [31:0] addr, logic [7:0] len, logic [2:0] size,
                               logic [1:0] burst, int wlast_at,
                               logic [63:0] d0, logic [63:0] d1, logic [63:0] d2,
                               logic [63:0] d3, logic [1:0] r0, logic [1:0] r1,
                               logic [1:0] r2, logic [1:0] r3);
      vec_t v;
      v.wr       = wr;
      v.addr     = addr;
      v.len      = len;
      v.size     = size;
      v.burst    = burst;
      v.wlast_at = wlast_at;
      v.strb     = {4{8'hFF}};
      v.data     = {d3, d2, d1, d0};
      v.resp     = {r3, r2, r1, r0};
      return v;
   endfunction

   // All tasks start and end at posedge+1.
   task automatic send_aw(input vec_t v, input logic [7:0] id, input string tag);
      int t = 0;
      i_awid = id; i_awaddr = v.addr; i_awlen = v.len; i_awsize = v.size; i_awburst = v.burst;
      i_awvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!o_awready && t < 50);
      check({tag, "_awready"}, 64'(o_awready), 64'd1);
      @(posedge clk); #1;
      i_awvalid = 1'b0;
   endtask

   task automatic send_ar(input vec_t v, input logic [7:0] id, input string tag);
      int t = 0;
      i_arid = id; i_araddr = v.addr; i_arlen = v.len; i_arsize = v.size; i_arburst = v.burst;
      i_arvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!o_arready && t < 50);
      check({tag, "_arready"}, 64'(o_arready), 64'd1);
      @(posedge clk); #1;
      i_arvalid = 1'b0;
   endtask

   task automatic send_w_b(input vec_t v, input logic [7:0] id, input string tag);
      int t;
      for (int b = 0; b <= int'(v.len); b++) begin
         i_wdata = v.data[b]; i_wstrb = v.strb[b]; i_wlast = (b == v.wlast_at); i_wvalid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!o_wready && t < 50);
         if (!o_wready) check($sformatf("%s_wready_b%0d", tag, b), 64'(o_wready), 64'd1);
         @(posedge clk); #1;
      end
      i_wvalid = 1'b0; i_wlast = 1'b0;
      check({tag, "_bvalid_rise"}, 64'(o_bvalid), 64'd1);
      @(negedge clk);
      check({tag, "_bvalid_hold"}, 64'(o_bvalid), 64'd1);
      check({tag, "_bresp"}, 64'(o_bresp), 64'(v.resp[0]));
      check({tag, "_bid"}, 64'(o_bid), 64'(id));
      i_bready = 1'b1;
      @(posedge clk); #1;
      i_bready = 1'b0;
      @(negedge clk);
      check({tag, "_bvalid_drop"}, 64'(o_bvalid), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic recv_r(input vec_t v, input logic [7:0] id, input string tag);
      int t;
      @(negedge clk);
      check({tag, "_rvalid_early"}, 64'(o_rvalid), 64'd0);
      for (int b = 0; b <= int'(v.len); b++) begin
         t = 0;
         do begin @(negedge clk); t++; end while (!o_rvalid && t < 20);
         if (b == 0) check({tag, "_first_beat_lat"}, 64'(t), 64'd1);
         check($sformatf("%s_rvalid_b%0d", tag, b), 64'(o_rvalid), 64'd1);
         check($sformatf("%s_rdata_b%0d", tag, b), o_rdata, v.data[b]);
         check($sformatf("%s_rresp_b%0d", tag, b), 64'(o_rresp), 64'(v.resp[b]));
         check($sformatf("%s_rlast_b%0d", tag, b), 64'(o_rlast), 64'(b == int'(v.len)));
         check($sformatf("%s_rid_b%0d", tag, b), 64'(o_rid), 64'(id));
      end
      @(negedge clk);
      check({tag, "_rvalid_end"}, 64'(o_rvalid), 64'd0);
      @(posedge clk); #1;
   endtask

   vec_t vecs [NumVec];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t wv, rv;
      logic [63:0] saved_data;
      logic [1:0]  saved_resp;
      logic        saved_last, stalled, gw, gr;
      int          b;

      rst_n = 1'b0;
      i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
      i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
      i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
      i_rready = 1'b1;

      vecs[0]  = mk(1, 32'h100, 8'd3, 3'd3, BURST_INCR, 3, D0, D1, D2, D3, 0, 0, 0, 0);
      vecs[1]  = mk(0, 32'h100, 8'd3, 3'd3, BURST_INCR, -1, D0, D1, D2, D3, 0, 0, 0, 0);
      vecs[2]  = mk(0, 32'h118, 8'd3, 3'd3, BURST_WRAP, -1, D3, D0, D1, D2, 0, 0, 0, 0);
      vecs[3]  = mk(0, 32'h108, 8'd2, 3'd3, BURST_FIXED, -1, D1, D1, D1, Z, 0, 0, 0, 0);
      vecs[4]  = mk(1, 32'h200, 8'd0, 3'd3, BURST_FIXED, 0, 64'hFFFF_FFFF_FFFF_FFFF, Z, Z, Z,
                    0, 0, 0, 0);
      vecs[5]  = mk(1, 32'h200, 8'd0, 3'd3, BURST_FIXED, 0, 64'h1122_3344_5566_7788, Z, Z, Z,
                    0, 0, 0, 0);
      vecs[5].strb[0] = 8'h0F;
      vecs[6]  = mk(0, 32'h200, 8'd0, 3'd3, BURST_INCR, -1, 64'hFFFF_FFFF_5566_7788, Z, Z, Z,
                    0, 0, 0, 0);
      vecs[7]  = mk(0, 32'h10000, 8'd0, 3'd3, BURST_INCR, -1, Z, Z, Z, Z, RESP_DECERR, 0, 0, 0);
      vecs[8]  = mk(1, 32'h300, 8'd1, 3'd3, BURST_INCR, 0, D0, D1, Z, Z, RESP_SLVERR, 0, 0, 0);
      vecs[9]  = mk(1, 32'h300, 8'd1, 3'd3, BURST_INCR, -1, D2, D3, Z, Z, RESP_SLVERR, 0, 0, 0);
      vecs[10] = mk(1, 32'hFFF8, 8'd1, 3'd3, BURST_INCR, 1, D2, D3, Z, Z, RESP_DECERR, 0, 0, 0);
      vecs[11] = mk(0, 32'hFFF8, 8'd1, 3'd3, BURST_INCR, -1, D2, Z, Z, Z, 0, RESP_DECERR, 0, 0);
      vecs[12] = mk(1, 32'h400, 8'd1, 3'd2, BURST_INCR, 1, 64'h0000_0000_AAAA_AAAA,
                    64'hBBBB_BBBB_0000_0000, Z, Z, 0, 0, 0, 0);
      vecs[12].strb[0] = 8'h0F;
      vecs[12].strb[1] = 8'hF0;
      vecs[13] = mk(0, 32'h400, 8'd0, 3'd3, BURST_INCR, -1, 64'hBBBB_BBBB_AAAA_AAAA, Z, Z, Z,
                    0, 0, 0, 0);
      vecs[14] = mk(1, 32'h508, 8'd2, 3'd3, BURST_WRAP, 2, D0, D1, D2, Z, 0, 0, 0, 0);
      vecs[15] = mk(0, 32'h508, 8'd2, 3'd3, BURST_INCR, -1, D0, D1, D2, Z, 0, 0, 0, 0);
      vecs[16] = mk(1, 32'h0, 8'd0, 3'd3, BURST_FIXED, 0, D3, Z, Z, Z, 0, 0, 0, 0);
      vecs[17] = mk(0, 32'hFFFF_FFF8, 8'd1, 3'd3, BURST_INCR, -1, Z, D3, Z, Z, RESP_DECERR, 0,
                    0, 0);
      vecs[18] = mk(0, 32'h104, 8'd1, 3'd2, BURST_WRAP, -1, D0, D0, Z, Z, 0, 0, 0, 0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 64'(o_awready), 64'd0);
      check("rst_arready", 64'(o_arready), 64'd0);
      check("rst_wready", 64'(o_wready), 64'd0);
      check("rst_bvalid", 64'(o_bvalid), 64'd0);
      check("rst_rvalid", 64'(o_rvalid), 64'd0);
      check("rst_rdata", o_rdata, 64'd0);
      check("rst_rlast", 64'(o_rlast), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NumVec; i++) begin
         if (vecs[i].wr) begin
            send_aw(vecs[i], 8'(8'h40 + i), $sformatf("v%0d", i));
            send_w_b(vecs[i], 8'(8'h40 + i), $sformatf("v%0d", i));
         end else begin
            send_ar(vecs[i], 8'(8'h80 + i), $sformatf("v%0d", i));
            recv_r(vecs[i], 8'(8'h80 + i), $sformatf("v%0d", i));
         end
      end

      // Simultaneous AW/AR: grant order W, R, W
      wv = mk(1, 32'h600, 8'd0, 3'd3, BURST_INCR, 0, D2, Z, Z, Z, 0, 0, 0, 0);
      rv = mk(0, 32'h600, 8'd0, 3'd3, BURST_INCR, -1, D2, Z, Z, Z, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         i_awid = 8'h11; i_awaddr = wv.addr; i_awlen = wv.len; i_awsize = wv.size;
         i_awburst = wv.burst;
         i_arid = 8'h22; i_araddr = rv.addr; i_arlen = rv.len; i_arsize = rv.size;
         i_arburst = rv.burst;
         i_awvalid = 1'b1; i_arvalid = 1'b1;
         @(negedge clk);
         gw = o_awready; gr = o_arready;
         check($sformatf("arb%0d_awready", k), 64'(gw), 64'(k != 1));
         check($sformatf("arb%0d_arready", k), 64'(gr), 64'(k == 1));
         @(posedge clk); #1;
         i_awvalid = 1'b0; i_arvalid = 1'b0;
         if (gw) send_w_b(wv, 8'h11, $sformatf("arb%0d", k));
         else if (gr) recv_r(rv, 8'h22, $sformatf("arb%0d", k));
      end

      // Random R back-pressure: payload must hold while stalled
      send_ar(vecs[1], 8'h33, "bp");
      b = 0; stalled = 1'b0;
      saved_data = '0; saved_resp = '0; saved_last = 1'b0;
      for (int cyc = 0; cyc < 200 && b <= 3; cyc++) begin
         @(posedge clk); #1;
         i_rready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (o_rvalid) begin
            if (stalled) begin
               check($sformatf("bp_hold_data_c%0d", cyc), o_rdata, saved_data);
               check($sformatf("bp_hold_resp_c%0d", cyc), 64'(o_rresp), 64'(saved_resp));
               check($sformatf("bp_hold_last_c%0d", cyc), 64'(o_rlast), 64'(saved_last));
            end
            if (i_rready) begin
               check($sformatf("bp_rdata_b%0d", b), o_rdata, vecs[1].data[b]);
               check($sformatf("bp_rlast_b%0d", b), 64'(o_rlast), 64'(b == 3));
               b++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               saved_data = o_rdata; saved_resp = o_rresp; saved_last = o_rlast;
            end
         end
      end
      check("bp_all_beats", 64'(b), 64'd4);
      @(posedge clk); #1;
      i_rready = 1'b1;
      @(negedge clk);
      check("bp_rvalid_end", 64'(o_rvalid), 64'd0);
      @(posedge clk); #1;

      // Reset in the middle of a stalled read
      i_rready = 1'b0;
      send_ar(vecs[1], 8'h44, "rst");
      repeat (3) @(posedge clk);
      #1;
      check("rst_mid_rvalid_before", 64'(o_rvalid), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_rvalid", 64'(o_rvalid), 64'd0);
      check("rst_mid_rdata", o_rdata, 64'd0);
      check("rst_mid_rlast", 64'(o_rlast), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      i_rready = 1'b1;
      @(posedge clk); #1;
      send_ar(vecs[6], 8'h55, "post_rst");
      recv_r(vecs[6], 8'h55, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
